grf_wb_queue: RTL and testbench

Write-side front end for the general register file. It collects register write requests from two producers and serializes them into the GRF's single write port, one write per cycle, in arrival order:
- the pipeline W stage (`pipe_*`);
- a long-latency unit such as the MDU or a load return (`aux_*`).

It also exposes a scoreboard/forward view of queued writes, so D-stage hazard logic can see values not yet committed to the GRF.

---
 rtl/grf_wb_queue.sv | 155 +++++++++++++++
 tb/tb_grf_wb_queue.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grf_wb_queue.sv
// ---------------------------------------------------------------------------
// grf_wb_queue
//
// Write-side front end for the general register file. Register write
// requests from the pipeline W stage (pipe_*) and from a long-latency unit
// (aux_*) are collected in a small circular buffer and drained into the
// GRF's single write port, one write per cycle, in arrival order. Queued
// writes are also exposed to D-stage hazard logic through two forwarding
// lookup ports, since the GRF does not hold those values yet.
//
// Optional feature (macro GRF_WB_QUEUE_TRACE_EN): when defined, every
// committed write is printed in simulation as "@pc: $reg <= data".
// Functional behaviour is identical with or without the macro.
//
// Ports:
//   clk, reset                       rising-edge clock, sync active-high reset
//   pipe_valid/addr/data/pc          W-stage write request
//   pipe_ready                       pipe request accepted this cycle
//   aux_valid/addr/data/pc           long-latency unit write request
//   aux_ready                        aux request accepted this cycle
//   reg_write, WriteAddr, RegData    GRF write port (head of queue)
//   WritePC                          PC of the write being committed
//   query_addr1/2                    forwarding lookup addresses (Rs/Rt)
//   fwd_hit1/2, fwd_data1/2          youngest queued value for each lookup
//   count                            current occupancy
// ---------------------------------------------------------------------------
module grf_wb_queue #(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pipe_valid,
   input  logic [4:0]       pipe_addr,
   input  logic [31:0]      pipe_data,
   input  logic [31:0]      pipe_pc,
   output logic             pipe_ready,
   input  logic             aux_valid,
   input  logic [4:0]       aux_addr,
   input  logic [31:0]      aux_data,
   input  logic [31:0]      aux_pc,
   output logic             aux_ready,
   output logic             reg_write,
   output logic [4:0]       WriteAddr,
   output logic [31:0]      RegData,
   output logic [31:0]      WritePC,
   input  logic [4:0]       query_addr1,
   input  logic [4:0]       query_addr2,
   output logic             fwd_hit1,
   output logic [31:0]      fwd_data1,
   output logic             fwd_hit2,
   output logic [31:0]      fwd_data2,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [4:0]       addr_mem [DEPTH];
   logic [31:0]      data_mem [DEPTH];
   logic [31:0]      pc_mem   [DEPTH];

   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W-1:0] aux_slot;
   logic [CNT_W-1:0] free;
   logic             pipe_push;
   logic             aux_push;
   logic             pop;

   // Acceptance is decided from the registered occupancy only, so a
   // full queue stays full for one cycle even though the head pops.
   assign free       = CNT_W'(DEPTH) - count;
   assign pipe_ready = !reset && (free >= CNT_W'(1));
   // Address 0 handshakes complete but never occupy a slot.
   assign pipe_push  = pipe_valid && pipe_ready && (pipe_addr != 5'd0);
   assign aux_ready  = !reset && (free >= (pipe_push ? CNT_W'(2) : CNT_W'(1)));
   assign aux_push   = aux_valid && aux_ready && (aux_addr != 5'd0);
   // The GRF always accepts, so any occupied head retires every cycle.
   assign pop        = (count != '0);

   // Pipe is older than a same-cycle aux request: it takes the tail slot.
   assign aux_slot   = tail + PTR_W'(pipe_push);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
         head  <= '0;
         tail  <= '0;
      end else begin
         count <= count + CNT_W'(pipe_push) + CNT_W'(aux_push) - CNT_W'(pop);
         head  <= head + PTR_W'(pop);
         tail  <= tail + PTR_W'(pipe_push) + PTR_W'(aux_push);
      end
   end

   // NOTE: the storage array is deliberately not reset; entries are only
   // observed while count marks them valid, and count is reset.
   always_ff @(posedge clk) begin
      if (pipe_push) begin
         addr_mem[tail] <= pipe_addr;
         data_mem[tail] <= pipe_data;
         pc_mem[tail]   <= pipe_pc;
      end
      if (aux_push) begin
         addr_mem[aux_slot] <= aux_addr;
         data_mem[aux_slot] <= aux_data;
         pc_mem[aux_slot]   <= aux_pc;
      end
   end

   // GRF write port: head entry, forced to zero when the queue is empty.
   always_comb begin
      reg_write = pop;
      WriteAddr = pop ? addr_mem[head] : 5'd0;
      RegData   = pop ? data_mem[head] : 32'd0;
      WritePC   = pop ? pc_mem[head]   : 32'd0;
   end

   // Forwarding walks valid entries from oldest (head) to youngest, so a
   // later match overwrites an earlier one and the youngest value wins.
   // The head is included because its value is not in the GRF yet.
   // NOTE: every output of this block gets a default first, so no latch
   // is inferred when no entry matches.
   always_comb begin
      fwd_hit1  = 1'b0;
      fwd_data1 = 32'd0;
      fwd_hit2  = 1'b0;
      fwd_data2 = 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
         if (CNT_W'(i) < count) begin
            if (query_addr1 != 5'd0 &&
                addr_mem[head + PTR_W'(i)] == query_addr1) begin
               fwd_hit1  = 1'b1;
               fwd_data1 = data_mem[head + PTR_W'(i)];
            end
            if (query_addr2 != 5'd0 &&
                addr_mem[head + PTR_W'(i)] == query_addr2) begin
               fwd_hit2  = 1'b1;
               fwd_data2 = data_mem[head + PTR_W'(i)];
            end
         end
      end
   end

`ifdef GRF_WB_QUEUE_TRACE_EN
   always_ff @(posedge clk) begin
      if (!reset && pop)
         $display("@%h: $%d <= %h", WritePC, WriteAddr, RegData);
   end
`else
`endif

endmodule

// File: tb/tb_grf_wb_queue.sv
// ---------------------------------------------------------------------------
// tb_grf_wb_queue
//
// Directed bench for grf_wb_queue (DEPTH = 4). Inputs change 1 ns after a
// rising edge; registered outputs are checked right after that, and the
// combinational ready/forward outputs 1 ns after the new inputs settle.
// ---------------------------------------------------------------------------
module tb_grf_wb_queue;

   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             clk;
   logic             reset;
   logic             pipe_valid;
   logic [4:0]       pipe_addr;
   logic [31:0]      pipe_data;
   logic [31:0]      pipe_pc;
   logic             pipe_ready;
   logic             aux_valid;
   logic [4:0]       aux_addr;
   logic [31:0]      aux_data;
   logic [31:0]      aux_pc;
   logic             aux_ready;
   logic             reg_write;
   logic [4:0]       WriteAddr;
   logic [31:0]      RegData;
   logic [31:0]      WritePC;
   logic [4:0]       query_addr1;
   logic [4:0]       query_addr2;
   logic             fwd_hit1;
   logic [31:0]      fwd_data1;
   logic             fwd_hit2;
   logic [31:0]      fwd_data2;
   logic [CNT_W-1:0] count;

   int checks_total  = 0;
   int checks_failed = 0;

   grf_wb_queue #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .pipe_valid  (pipe_valid),
      .pipe_addr   (pipe_addr),
      .pipe_data   (pipe_data),
      .pipe_pc     (pipe_pc),
      .pipe_ready  (pipe_ready),
      .aux_valid   (aux_valid),
      .aux_addr    (aux_addr),
      .aux_data    (aux_data),
      .aux_pc      (aux_pc),
      .aux_ready   (aux_ready),
      .reg_write   (reg_write),
      .WriteAddr   (WriteAddr),
      .RegData     (RegData),
      .WritePC     (WritePC),
      .query_addr1 (query_addr1),
      .query_addr2 (query_addr2),
      .fwd_hit1    (fwd_hit1),
      .fwd_data1   (fwd_data1),
      .fwd_hit2    (fwd_hit2),
      .fwd_data2   (fwd_data2),
      .count       (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the sequence ever stalls.
   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout, required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks_total++;
      assert (obs === exp)
      else begin
         checks_failed++;
         $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_pipe(input logic v, input logic [4:0] a,
                             input logic [31:0] d, input logic [31:0] pc);
      pipe_valid = v;
      pipe_addr  = a;
      pipe_data  = d;
      pipe_pc    = pc;
   endtask

   task automatic drive_aux(input logic v, input logic [4:0] a,
                            input logic [31:0] d, input logic [31:0] pc);
      aux_valid = v;
      aux_addr  = a;
      aux_data  = d;
      aux_pc    = pc;
   endtask

   initial begin
      reset       = 1'b1;
      query_addr1 = 5'd5;
      query_addr2 = 5'd0;
      drive_pipe(1'b0, 5'd0, 32'd0, 32'd0);
      drive_aux (1'b0, 5'd0, 32'd0, 32'd0);
      tick();
      tick();

      // Reset state, reset still high.
      check("rst_count",      32'(count),  32'd0);
      check("rst_reg_write",  32'(reg_write), 32'd0);
      check("rst_waddr",      32'(WriteAddr), 32'd0);
      check("rst_regdata",    RegData,     32'd0);
      check("rst_wpc",        WritePC,     32'd0);
      check("rst_fwd_hit1",   32'(fwd_hit1), 32'd0);
      check("rst_fwd_data1",  fwd_data1,   32'd0);
      check("rst_pipe_ready", 32'(pipe_ready), 32'd0);
      check("rst_aux_ready",  32'(aux_ready),  32'd0);
      reset = 1'b0;

      // 1. Single write.
      drive_pipe(1'b1, 5'd5, 32'h1234_5678, 32'h0000_3000);
      #1;
      check("t1_pipe_ready", 32'(pipe_ready), 32'd1);
      tick();
      drive_pipe(1'b0, 5'd0, 32'd0, 32'd0);
      check("t1_reg_write", 32'(reg_write), 32'd1);
      check("t1_waddr",     32'(WriteAddr), 32'd5);
      check("t1_regdata",   RegData,        32'h1234_5678);
      check("t1_wpc",       WritePC,        32'h0000_3000);
      check("t1_count",     32'(count),     32'd1);
      check("t1_head_hit",  32'(fwd_hit1),  32'd1);
      check("t1_head_data", fwd_data1,      32'h1234_5678);
      tick();
      check("t1_count_drained", 32'(count),     32'd0);
      check("t1_reg_write_off", 32'(reg_write), 32'd0);
      check("t1_waddr_zero",    32'(WriteAddr), 32'd0);
      check("t1_hit_gone",      32'(fwd_hit1),  32'd0);

      // 2. Simultaneous producers: pipe is older.
      drive_pipe(1'b1, 5'd3, 32'h0000_000A, 32'h0000_3004);
      drive_aux (1'b1, 5'd4, 32'h0000_000B, 32'h0000_3008);
      #1;
      check("t2_aux_ready", 32'(aux_ready), 32'd1);
      tick();
      drive_pipe(1'b0, 5'd0, 32'd0, 32'd0);
      drive_aux (1'b0, 5'd0, 32'd0, 32'd0);
      check("t2_count",    32'(count),     32'd2);
      check("t2_waddr_a",  32'(WriteAddr), 32'd3);
      check("t2_data_a",   RegData,        32'h0000_000A);
      tick();
      check("t2_count_b",  32'(count),     32'd1);
      check("t2_waddr_b",  32'(WriteAddr), 32'd4);
      check("t2_data_b",   RegData,        32'h0000_000B);
      check("t2_wpc_b",    WritePC,        32'h0000_3008);
      tick();
      check("t2_count_end", 32'(count),    32'd0);

      // 3. Backpressure: three cycles of both producers valid.
      drive_pipe(1'b1, 5'd10, 32'h10, 32'h100);
      drive_aux (1'b1, 5'd11, 32'h11, 32'h104);
      tick();
      check("t3_count_c1", 32'(count),     32'd2);
      check("t3_head_c1",  32'(WriteAddr), 32'd10);
      drive_pipe(1'b1, 5'd12, 32'h12, 32'h108);
      drive_aux (1'b1, 5'd13, 32'h13, 32'h10C);
      #1;
      check("t3_aux_ready_c2", 32'(aux_ready), 32'd1);
      tick();
      check("t3_count_c2", 32'(count),     32'd3);
      check("t3_head_c2",  32'(WriteAddr), 32'd11);
      drive_pipe(1'b1, 5'd14, 32'h14, 32'h110);
      drive_aux (1'b1, 5'd15, 32'h15, 32'h114);
      #1;
      check("t3_pipe_ready_c3", 32'(pipe_ready), 32'd1);
      check("t3_aux_ready_c3",  32'(aux_ready),  32'd0);
      tick();
      check("t3_count_c3", 32'(count),     32'd3);
      check("t3_head_c3",  32'(WriteAddr), 32'd12);
      // Re-present the rejected aux request alone.
      drive_pipe(1'b0, 5'd0, 32'd0, 32'd0);
      #1;
      check("t3_aux_ready_retry", 32'(aux_ready), 32'd1);
      tick();
      drive_aux(1'b0, 5'd0, 32'd0, 32'd0);
      check("t3_count_retry", 32'(count),     32'd3);
      check("t3_head_13",     32'(WriteAddr), 32'd13);
      tick();
      check("t3_head_14",     32'(WriteAddr), 32'd14);
      tick();
      check("t3_head_15",     32'(WriteAddr), 32'd15);
      check("t3_data_15",     RegData,        32'h15);
      check("t3_wpc_15",      WritePC,        32'h114);
      tick();
      check("t3_count_end",   32'(count),     32'd0);

      // 4. Zero-address pipe request with count = 3.
      drive_pipe(1'b1, 5'd20, 32'h20, 32'h200);
      drive_aux (1'b1, 5'd21, 32'h21, 32'h204);
      tick();
      drive_pipe(1'b1, 5'd22, 32'h22, 32'h208);
      drive_aux (1'b1, 5'd23, 32'h23, 32'h20C);
      tick();
      check("t4_count_pre", 32'(count), 32'd3);
      drive_pipe(1'b1, 5'd0,  32'hDEAD_BEEF, 32'h210);
      drive_aux (1'b1, 5'd24, 32'h24, 32'h214);
      #1;
      check("t4_pipe_ready", 32'(pipe_ready), 32'd1);
      check("t4_aux_ready",  32'(aux_ready),  32'd1);
      tick();
      drive_pipe(1'b0, 5'd0, 32'd0, 32'd0);
      drive_aux (1'b0, 5'd0, 32'd0, 32'd0);
      // Only aux pushed, head popped: occupancy stays 3.
      check("t4_count_post", 32'(count),     32'd3);
      check("t4_head_22",    32'(WriteAddr), 32'd22);
      tick();
      check("t4_head_23",    32'(WriteAddr), 32'd23);
      tick();
      check("t4_head_24",    32'(WriteAddr), 32'd24);
      check("t4_data_24",    RegData,        32'h24);
      tick();
      check("t4_drained",    32'(reg_write), 32'd0);

      // 5. Forwarding.
      query_addr1 = 5'd7;
      query_addr2 = 5'd9;
      drive_pipe(1'b1, 5'd7, 32'h1, 32'h300);
      drive_aux (1'b1, 5'd7, 32'h2, 32'h304);
      tick();
      drive_aux (1'b0, 5'd0, 32'd0, 32'd0);
      drive_pipe(1'b1, 5'd9, 32'h3, 32'h308);
      #1;
      check("t5_hit1_young",   32'(fwd_hit1), 32'd1);
      check("t5_data1_young",  fwd_data1,     32'h2);
      check("t5_incoming_hit", 32'(fwd_hit2), 32'd0);
      tick();
      drive_pipe(1'b0, 5'd0, 32'd0, 32'd0);
      check("t5_hit1",  32'(fwd_hit1), 32'd1);
      check("t5_data1", fwd_data1,     32'h2);
      check("t5_hit2_9",  32'(fwd_hit2), 32'd1);
      check("t5_data2_9", fwd_data2,     32'h3);
      query_addr2 = 5'd0;
      #1;
      check("t5_hit2_zero",  32'(fwd_hit2), 32'd0);
      check("t5_data2_zero", fwd_data2,     32'd0);
      tick();
      check("t5_hit1_gone",  32'(fwd_hit1), 32'd0);
      check("t5_data1_gone", fwd_data1,     32'd0);
      tick();
      check("t5_count_end",  32'(count),    32'd0);

      // 6. Reset mid-operation with count = 3.
      drive_pipe(1'b1, 5'd25, 32'h25, 32'h400);
      drive_aux (1'b1, 5'd26, 32'h26, 32'h404);
      tick();
      drive_pipe(1'b1, 5'd27, 32'h27, 32'h408);
      drive_aux (1'b1, 5'd28, 32'h28, 32'h40C);
      tick();
      drive_pipe(1'b0, 5'd0, 32'd0, 32'd0);
      drive_aux (1'b0, 5'd0, 32'd0, 32'd0);
      check("t6_count_pre", 32'(count), 32'd3);
      reset = 1'b1;
      #1;
      check("t6_pipe_ready_rst", 32'(pipe_ready), 32'd0);
      check("t6_aux_ready_rst",  32'(aux_ready),  32'd0);
      tick();
      check("t6_count",        32'(count),      32'd0);
      check("t6_reg_write",    32'(reg_write),  32'd0);
      check("t6_pipe_ready_h", 32'(pipe_ready), 32'd0);
      reset = 1'b0;
      #1;
      check("t6_pipe_ready_rel", 32'(pipe_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t6_no_write", 32'(reg_write), 32'd0);
      end

      $display("%0d/%0d checks passed", checks_total - checks_failed,
               checks_total);
      $finish;
   end

endmodule
